// File: rtl/alu_result_writeback_pkg.sv
// alu_result_writeback_pkg: ALU opcodes, writeback select encodings and result entry type.
package alu_result_writeback_pkg;
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3,
                           OP_AND = 5'd4,  OP_OR  = 5'd5,  OP_XOR = 5'd6,  OP_NOR = 5'd7,
                           OP_SLT = 5'd8,  OP_SLL = 5'd9,  OP_SRL = 5'd10, OP_SRA = 5'd11,
                           OP_ROR = 5'd12;
    localparam logic [1:0] WB_GPR = 2'b00, WB_LO = 2'b01, WB_HI = 2'b10;

    // Default-width entry (DATA_W=32, DEST_W=4)
    typedef struct packed {
        logic [63:0] c;
        logic [4:0]  opcode;
        logic [3:0]  dest;
    } res_entry_t;

    function automatic logic is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction
endpackage

// File: rtl/alu_result_writeback_sync_fifo.sv
// sync_fifo: generic DEPTH x WIDTH register FIFO with synchronous clear.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;

    assign count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while empty
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/alu_result_writeback.sv
// alu_result_writeback: buffers ALU results and drains them to the 32-bit register-file port,
// splitting MUL/DIV results into LO then HI beats.
module alu_result_writeback
    import alu_result_writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int DEST_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_c,
    input  logic [4:0]          in_opcode,
    input  logic [DEST_W-1:0]   in_dest,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [DATA_W-1:0]   wb_data,
    output logic [1:0]          wb_sel,
    output logic [DEST_W-1:0]   wb_dest,
    output logic                wb_zero,
    output logic                wb_last
);
    typedef struct packed {
        logic [2*DATA_W-1:0] c;
        logic [4:0]          opcode;
        logic [DEST_W-1:0]   dest;
    } entry_t;

    entry_t wdata, head;
    logic   full, empty, push, pop, beat, wide, hi_q, hi_d;

    assign wdata    = '{c: in_c, opcode: in_opcode, dest: in_dest};
    assign in_ready = !full && !flush;
    assign wb_valid = !empty && !flush;
    assign push     = in_valid && in_ready;
    assign beat     = wb_valid && wb_ready;
    assign wide     = is_wide(head.opcode);
    assign pop      = beat && (!wide || hi_q);
    assign hi_d     = flush ? 1'b0 : (beat && wide) ? !hi_q : hi_q;

    sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hi_q <= 1'b0;
        else hi_q <= hi_d;
    end

    // Outputs are forced to idle values whenever no beat is presented
    always_comb begin
        wb_data = !wb_valid ? '0 : (wide && hi_q) ? head.c[2*DATA_W-1:DATA_W] : head.c[DATA_W-1:0];
        wb_sel  = !wb_valid ? WB_GPR : !wide ? WB_GPR : hi_q ? WB_HI : WB_LO;
        wb_dest = (wb_valid && !wide) ? head.dest : '0;
        wb_last = wb_valid && (!wide || hi_q);
        wb_zero = wb_data == '0;
    end
endmodule

// File: tb/tb_alu_result_writeback.sv
// tb_alu_result_writeback: table-driven and scoreboard checks of the writeback stage.
module tb_alu_result_writeback;
    import alu_result_writeback_pkg::*;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, wb_ready = 0;
    logic [63:0] in_c = '0;
    logic [4:0]  in_opcode = '0;
    logic [3:0]  in_dest = '0;
    logic        in_ready, wb_valid, wb_zero, wb_last;
    logic [31:0] wb_data;
    logic [1:0]  wb_sel;
    logic [3:0]  wb_dest;

    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        logic [3:0]  t;
        logic        l;
    } beat_t;

    typedef struct {
        res_entry_t e;
        int         nb;
        beat_t      b0;
        beat_t      b1;
    } vec_t;

    beat_t sb[$];
    vec_t  vt[5];

    alu_result_writeback #(.DATA_W(32), .DEPTH(2), .DEST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c), .in_opcode(in_opcode), .in_dest(in_dest),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_sel(wb_sel),
        .wb_dest(wb_dest), .wb_zero(wb_zero), .wb_last(wb_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_in_ready"}, in_ready, 1);
        chk({n, "_wb_valid"}, wb_valid, 0);
        chk({n, "_wb_data"}, wb_data, 0);
        chk({n, "_wb_sel"}, wb_sel, 0);
        chk({n, "_wb_dest"}, wb_dest, 0);
        chk({n, "_wb_zero"}, wb_zero, 1);
        chk({n, "_wb_last"}, wb_last, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] c, input logic [4:0] op, input logic [3:0] dest);
        int n = 0;
        while (!in_ready && n < 100) begin
            cyc();
            n++;
        end
        chk("push_ready_timeout", in_ready, 1);
        in_valid = 1; in_c = c; in_opcode = op; in_dest = dest;
        cyc();
        in_valid = 0;
    endtask

    task automatic drain(input string n);
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            cyc();
            k++;
        end
        chk({n, "_drain"}, sb.size(), 0);
    endtask

    // Scoreboard: compare each accepted beat against the oldest expected beat
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat got data %0h sel %0h want no beat", wb_data, wb_sel);
            end else begin
                beat_t b;
                b = sb.pop_front();
                chk("beat_data", wb_data, b.d);
                chk("beat_sel", wb_sel, b.s);
                chk("beat_dest", wb_dest, b.t);
                chk("beat_last", wb_last, b.l);
                chk("beat_zero", wb_zero, b.d == 0);
            end
        end
    end

    initial begin
        vt[0] = '{'{64'h0000_0000_0000_0005, OP_ADD, 4'd3}, 1, '{32'h5, WB_GPR, 4'd3, 1'b1}, '{0, 0, 0, 0}};
        vt[1] = '{'{64'h0000_0001_FFFF_FFFE, OP_MUL, 4'd4}, 2, '{32'hFFFF_FFFE, WB_LO, 4'd0, 1'b0},
                  '{32'h0000_0001, WB_HI, 4'd0, 1'b1}};
        vt[2] = '{'{64'hDEAD_BEEF_0000_0000, OP_DIV, 4'd2}, 2, '{32'h0, WB_LO, 4'd0, 1'b0},
                  '{32'hDEAD_BEEF, WB_HI, 4'd0, 1'b1}};
        vt[3] = '{'{64'h0, 5'd13, 4'd7}, 1, '{32'h0, WB_GPR, 4'd7, 1'b1}, '{0, 0, 0, 0}};
        vt[4] = '{'{64'hFFFF_FFFF_1234_5678, OP_ROR, 4'd15}, 1, '{32'h1234_5678, WB_GPR, 4'd15, 1'b1},
                  '{0, 0, 0, 0}};

        #12 chk_idle("reset");
        rst_n = 1;
        cyc();

        wb_ready = 1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(vt[i].b0);
            if (vt[i].nb == 2) sb.push_back(vt[i].b1);
            push(vt[i].e.c, vt[i].e.opcode, vt[i].e.dest);
            chk($sformatf("latency_%0d", i), wb_valid, 1);
            drain($sformatf("vec_%0d", i));
            chk($sformatf("empty_after_%0d", i), wb_valid, 0);
        end

        wb_ready = 0;
        sb.push_back('{32'h11, WB_GPR, 4'd8, 1'b1});
        sb.push_back('{32'h22, WB_GPR, 4'd9, 1'b1});
        push(64'h11, OP_SUB, 4'd8);
        push(64'h22, OP_AND, 4'd9);
        chk("full_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", wb_valid, 1);
            chk("stall_data", wb_data, 32'h11);
            chk("stall_dest", wb_dest, 4'd8);
            cyc();
        end
        wb_ready = 1;
        cyc();
        chk("ready_after_pop", in_ready, 1);
        drain("backpressure");

        for (int i = 1; i <= 6; i++) begin
            sb.push_back('{32'(i), WB_GPR, 4'(i), 1'b1});
            in_valid = 1; in_c = 64'(i); in_opcode = OP_ADD; in_dest = 4'(i);
            if (i > 1) chk($sformatf("no_bubble_%0d", i), wb_valid, 1);
            chk($sformatf("stream_ready_%0d", i), in_ready, 1);
            cyc();
        end
        in_valid = 0;
        drain("stream");

        wb_ready = 0;
        sb.push_back('{32'h9, WB_LO, 4'd0, 1'b0});
        push(64'h0000_0007_0000_0009, OP_DIV, 4'd5);
        wb_ready = 1;
        cyc();
        flush = 1;
        #1;
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_in_ready", in_ready, 0);
        cyc();
        flush = 0;
        for (int i = 0; i < 3; i++) begin
            chk("post_flush_valid", wb_valid, 0);
            cyc();
        end
        chk("post_flush_ready", in_ready, 1);
        drain("flush");

        wb_ready = 0;
        sb.push_back('{32'hAAAA_5555, WB_LO, 4'd0, 1'b0});
        push(64'h1234_0000_AAAA_5555, OP_MUL, 4'd6);
        wb_ready = 1;
        cyc();
        wb_ready = 0;
        chk("hi_before_reset", wb_sel, WB_HI);
        #2 rst_n = 0;
        #1 chk_idle("mid_reset");
        cyc();
        rst_n = 1;
        wb_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("post_reset_valid", wb_valid, 0);
            cyc();
        end
        drain("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
